// File: rtl/modexp_sched_if.sv
// modexp_sched_if: bundles the request, response and engine-side signals of
// the modular-exponentiation scheduler.
//   req_*  : NREQ requesters, packed operands (requester i at [i*W +: W])
//   rsp_*  : single tagged response channel
//   eng_*  : engine start/operands and finish/result
//   busy   : scheduler not idle
// Modports: slave = scheduler side, master = clients/engine/environment side.
interface modexp_sched_if #(
  parameter int unsigned ARQ  = 16,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned W   = 2*ARQ;
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_base;
  logic [NREQ*W-1:0] req_modulo;
  logic [NREQ*W-1:0] req_exponent;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;
  logic              busy;

  logic              eng_start;
  logic [W-1:0]      eng_base;
  logic [W-1:0]      eng_modulo;
  logic [W-1:0]      eng_exponent;
  logic              eng_finish;
  logic [W-1:0]      eng_result;

  modport slave (
    input  req_valid, req_base, req_modulo, req_exponent,
    input  rsp_ready, eng_finish, eng_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
    output eng_start, eng_base, eng_modulo, eng_exponent
  );

  modport master (
    output req_valid, req_base, req_modulo, req_exponent,
    output rsp_ready, eng_finish, eng_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
    input  eng_start, eng_base, eng_modulo, eng_exponent
  );
endinterface

// File: rtl/modexp_sched.sv
// modexp_sched: round-robin scheduler sharing one modular-exponentiation
// engine among NREQ requesters.
//   clk, reset : clock, synchronous active-high reset
//   bus        : modexp_sched_if.slave (requests, response, engine handshake)
// Operand sets whose modulus is zero or wider than ARQ bits, or whose base is
// wider than ARQ bits, are rejected with rsp_err=1 without starting the engine.
// Optional: define MODEXP_TIMEOUT_EN to add a RUN-state watchdog that returns
// rsp_err=1 after TIMEOUT_CYCLES cycles without eng_finish.
module modexp_sched #(
  parameter int unsigned ARQ            = 16,
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2*ARQ+8
) (
  input  logic          clk,
  input  logic          reset,
  modexp_sched_if.slave bus
);
  localparam int unsigned W   = 2*ARQ;
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   base_q, base_d;
  logic [W-1:0]   mod_q, mod_d;
  logic [W-1:0]   expo_q, expo_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;
  logic           armed_q, armed_d;
`ifdef MODEXP_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0]  cnt_q, cnt_d;
`endif

  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [W-1:0]   sel_base, sel_mod, sel_exp;
  logic           reject;

  // Round-robin search starting just after the last granted requester.
  always_comb begin : arbiter
    int unsigned    cand;
    logic [IDW-1:0] cand_id;
    grant_valid = 1'b0;
    grant_id    = last_q;
    cand        = 0;
    cand_id     = '0;
    for (int unsigned j = 1; j <= NREQ; j++) begin
      cand    = (32'(last_q) + j) % NREQ;
      cand_id = IDW'(cand);
      if (!grant_valid && bus.req_valid[cand_id]) begin
        grant_valid = 1'b1;
        grant_id    = cand_id;
      end
    end
    sel_base = bus.req_base[grant_id*W +: W];
    sel_mod  = bus.req_modulo[grant_id*W +: W];
    sel_exp  = bus.req_exponent[grant_id*W +: W];
    // Half-width operands keep every engine product within W bits.
    reject   = (sel_mod == '0) || (sel_mod[W-1:ARQ] != '0) ||
               (sel_base[W-1:ARQ] != '0);
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= IDW'(NREQ-1);
      id_q     <= '0;
      base_q   <= '0;
      mod_q    <= '0;
      expo_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
`ifdef MODEXP_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      expo_q   <= expo_d;
      result_q <= result_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
`ifdef MODEXP_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    base_d   = base_q;
    mod_d    = mod_q;
    expo_d   = expo_q;
    result_d = result_q;
    err_d    = err_q;
    // Low only in the first RUN cycle, so eng_finish left over from the
    // previous operation is not mistaken for completion.
    armed_d  = (state_q == S_RUN);
`ifdef MODEXP_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          last_d = grant_id;
          id_d   = grant_id;
          base_d = sel_base;
          mod_d  = sel_mod;
          expo_d = sel_exp;
          if (reject) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = S_RESP;
          end else begin
            state_d  = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_RUN;
`ifdef MODEXP_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_RUN: begin
`ifdef MODEXP_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (armed_q && bus.eng_finish) begin
          result_d = bus.eng_result;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end
`ifdef MODEXP_TIMEOUT_EN
        else if (cnt_q >= CW'(TIMEOUT_CYCLES-1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    bus.req_ready = '0;
    if ((state_q == S_IDLE) && grant_valid) bus.req_ready[grant_id] = 1'b1;
    bus.busy         = (state_q != S_IDLE);
    bus.eng_start    = (state_q == S_START);
    bus.rsp_valid    = (state_q == S_RESP);
    bus.rsp_id       = id_q;
    bus.rsp_result   = result_q;
    bus.rsp_err      = err_q;
    bus.eng_base     = base_q;
    bus.eng_modulo   = mod_q;
    bus.eng_exponent = expo_q;
  end
endmodule

// File: tb/tb_modexp_sched.sv
module tb_modexp_sched;
  localparam int unsigned ARQ  = 16;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 2*ARQ;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] modulo;
    logic [W-1:0] exponent;
  } op_t;

  typedef struct {
    int unsigned  id;
    logic [W-1:0] result;
    logic         err;
    int unsigned  lat;
    op_t          op;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  modexp_sched_if #(.ARQ(ARQ), .NREQ(NREQ)) bus ();

  modexp_sched #(.ARQ(ARQ), .NREQ(NREQ), .TIMEOUT_CYCLES(2*ARQ+8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  op_t         op_q[NREQ][$];
  exp_t        exp_q[$];
  int unsigned mdl_last = NREQ-1;
  int unsigned start_cnt = 0;

  logic              drv_en = 1'b0;
  logic              mon_en = 1'b0;
  int unsigned       rdy_mode = 0;
  logic [NREQ-1:0]   man_valid = '0;
  op_t               man_op;
  logic              man_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic int unsigned bitlen(input logic [W-1:0] e);
    int unsigned k = 0;
    for (int unsigned i = 0; i < W; i++) if (e[i]) k = i + 1;
    return k;
  endfunction

  // Reference: right-to-left square-and-multiply.
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] m,
                                              input logic [W-1:0] e);
    longint unsigned r = 1;
    longint unsigned x = 64'(b) % 64'(m);
    for (int unsigned i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return r[W-1:0];
  endfunction

  // Engine stub arithmetic: left-to-right, independent of the reference.
  function automatic logic [W-1:0] engine_pow(input logic [W-1:0] b, input logic [W-1:0] m,
                                              input logic [W-1:0] e);
    longint unsigned r = 1;
    if (m == '0) return '0;
    for (int i = W-1; i >= 0; i--) begin
      r = (r * r) % 64'(m);
      if (e[i]) r = (r * 64'(b)) % 64'(m);
    end
    return r[W-1:0];
  endfunction

  // Engine stub: finish appears k+2 cycles after the start cycle.
  int unsigned  eng_cnt = 0;
  logic         eng_fin = 1'b0;
  logic [W-1:0] eng_res = '0;
  always @(posedge clk) begin
    if (reset) begin
      eng_cnt <= 0;
      eng_fin <= 1'b0;
    end else if (bus.eng_start) begin
      eng_cnt <= bitlen(bus.eng_exponent) + 1;
      eng_fin <= 1'b0;
      eng_res <= engine_pow(bus.eng_base, bus.eng_modulo, bus.eng_exponent);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_fin <= 1'b1;
    end
  end
  assign bus.eng_finish = eng_fin;
  assign bus.eng_result = eng_res;

  // Driver: sole writer of DUT inputs; updates #1 after the rising edge.
  logic [NREQ-1:0] acc;
  int unsigned     resp_seen = 0;
  initial begin : driver
    bus.req_valid    = '0;
    bus.req_base     = '0;
    bus.req_modulo   = '0;
    bus.req_exponent = '0;
    bus.rsp_ready    = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (bus.rsp_valid) resp_seen++;
      else resp_seen = 0;
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (acc[i] && op_q[i].size() > 0) void'(op_q[i].pop_front());
          if (op_q[i].size() > 0) begin
            bus.req_valid[i]            = 1'b1;
            bus.req_base[i*W +: W]      = op_q[i][0].base;
            bus.req_modulo[i*W +: W]    = op_q[i][0].modulo;
            bus.req_exponent[i*W +: W]  = op_q[i][0].exponent;
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
        case (rdy_mode)
          0:       bus.rsp_ready = 1'b1;
          1:       bus.rsp_ready = 1'($urandom_range(0, 1));
          default: bus.rsp_ready = (resp_seen >= 5);
        endcase
      end else begin
        bus.req_valid = man_valid;
        for (int unsigned i = 0; i < NREQ; i++) begin
          bus.req_base[i*W +: W]     = man_op.base;
          bus.req_modulo[i*W +: W]   = man_op.modulo;
          bus.req_exponent[i*W +: W] = man_op.exponent;
        end
        bus.rsp_ready = man_ready;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  int unsigned  cyc = 0;
  int unsigned  grant_cyc = 0;
  logic         in_resp = 1'b0;
  logic [34:0]  snap = '0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (reset || !mon_en) begin
        in_resp = 1'b0;
        continue;
      end
      if (|bus.req_ready) begin
        grant_cyc = cyc;
        if (exp_q.size() == 0) check("grant_expected", 64'(bus.req_ready), '0);
        else check("grant_id", 64'(bus.req_ready), 64'(1) << exp_q[0].id);
        check("grant_while_busy", 64'(bus.busy), 0);
      end
      if (bus.eng_start) begin
        start_cnt++;
        if (exp_q.size() > 0) begin
          check("start_cycle", 64'(cyc - grant_cyc), 1);
          check("eng_base", 64'(bus.eng_base), 64'(exp_q[0].op.base));
          check("eng_modulo", 64'(bus.eng_modulo), 64'(exp_q[0].op.modulo));
          check("eng_exponent", 64'(bus.eng_exponent), 64'(exp_q[0].op.exponent));
        end
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_expected", 64'(bus.rsp_valid), 0);
        end else begin
          if (!in_resp) begin
            in_resp = 1'b1;
            check("rsp_latency", 64'(cyc - grant_cyc), 64'(exp_q[0].lat));
            snap = {bus.rsp_id, bus.rsp_result, bus.rsp_err};
          end else begin
            check("rsp_stable", 64'({bus.rsp_id, bus.rsp_result, bus.rsp_err}), 64'(snap));
          end
          if (bus.rsp_ready) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
            check("rsp_result", 64'(bus.rsp_result), 64'(exp_q[0].result));
            check("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0].err));
            void'(exp_q.pop_front());
            in_resp = 1'b0;
          end
        end
      end
    end
  end

  task automatic add_op(input int unsigned id, input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic [W-1:0] e);
    op_t o;
    o.base = b; o.modulo = m; o.exponent = e;
    op_q[id].push_back(o);
  endtask

  // Predict service order (round robin over loaded queues), then wait for drain.
  task automatic run_batch(input int unsigned budget);
    int unsigned idx[NREQ];
    int unsigned left = 0;
    int unsigned starts_exp = 0;
    int unsigned start_base;
    exp_t        e;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx[i] = 0;
      left += op_q[i].size();
    end
    while (left > 0) begin
      for (int unsigned j = 1; j <= NREQ; j++) begin
        int unsigned c;
        c = (mdl_last + j) % NREQ;
        if (idx[c] < op_q[c].size()) begin
          e.op     = op_q[c][idx[c]];
          e.id     = c;
          e.err    = (e.op.modulo == '0) || (e.op.modulo >= (W'(1) << ARQ)) ||
                     (e.op.base >= (W'(1) << ARQ));
          e.result = e.err ? '0 : ref_modexp(e.op.base, e.op.modulo, e.op.exponent);
          e.lat    = e.err ? 1 : bitlen(e.op.exponent) + 4;
          if (!e.err) starts_exp++;
          exp_q.push_back(e);
          idx[c]++;
          left--;
          mdl_last = c;
          break;
        end
      end
    end
    start_base = start_cnt;
    for (int unsigned n = 0; n < budget && exp_q.size() > 0; n++) @(posedge clk);
    if (exp_q.size() > 0) begin
      check("batch_drain", 64'(exp_q.size()), 0);
      exp_q.delete();
      for (int unsigned i = 0; i < NREQ; i++) op_q[i].delete();
    end
    repeat (2) @(negedge clk);
    check("start_count", 64'(start_cnt - start_base), 64'(starts_exp));
  endtask

  function automatic op_t rand_op();
    op_t o;
    int unsigned sel;
    sel = $urandom_range(0, 9);
    o.base     = W'($urandom_range(0, 65535));
    o.modulo   = W'($urandom_range(2, 65535));
    o.exponent = W'($urandom);
    case (sel)
      0: o.modulo = '0;
      1: o.modulo = {16'($urandom_range(1, 65535)), 16'($urandom)};
      2: o.base   = {16'($urandom_range(1, 65535)), 16'($urandom)};
      3: o.exponent = W'($urandom_range(0, 3));
      default: ;
    endcase
    return o;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic seen;
    op_t  o;
    man_op.base = '0; man_op.modulo = '0; man_op.exponent = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 0);
    check("reset_eng_start", 64'(bus.eng_start), 0);
    check("reset_req_ready", 64'(bus.req_ready), 0);
    check("reset_rsp_fields", 64'({bus.rsp_id, bus.rsp_result, bus.rsp_err}), 0);
    check("reset_eng_ops", 64'(bus.eng_base | bus.eng_modulo | bus.eng_exponent), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    drv_en = 1'b1;
    rdy_mode = 0;
    @(posedge clk);

    // Single request, known result.
    add_op(0, 4, 497, 13);
    run_batch(200);

    // Two requesters held valid: alternate grants.
    add_op(0, 3, 7, 2); add_op(0, 3, 7, 2);
    add_op(1, 3, 7, 2); add_op(1, 3, 7, 2);
    run_batch(400);

    // Rejected operand sets.
    add_op(2, 5, 0, 3);
    add_op(3, 5, 32'h0001_0000, 3);
    run_batch(100);

    // Backpressure: rsp_ready low for 5 RESP cycles.
    rdy_mode = 2;
    add_op(1, 9, 1000, 5);
    run_batch(200);
    rdy_mode = 0;

    // Exponent zero.
    add_op(2, 7, 11, 0);
    run_batch(100);

    // Reset in RUN abandons the transaction.
    mon_en = 1'b0;
    man_ready = 1'b1;
    man_op.base = 5; man_op.modulo = 1000; man_op.exponent = 32'h0000_FFFF;
    man_valid = 4'b0100;
    drv_en = 1'b0;
    seen = 1'b0;
    for (int unsigned n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.req_ready[2];
    end
    check("rst_pre_grant", 64'(seen), 1);
    man_valid = '0;
    repeat (2) @(negedge clk);
    check("rst_in_run_busy", 64'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    check("rst_outputs", 64'({bus.req_ready, bus.eng_start, bus.rsp_id, bus.rsp_result, bus.rsp_err}), 0);
    check("rst_eng_ops", 64'(bus.eng_base | bus.eng_modulo | bus.eng_exponent), 0);
    seen = 1'b0;
    for (int unsigned n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.eng_start) seen = 1'b1;
    end
    check("rst_no_response", 64'(seen), 0);
    mdl_last = NREQ-1;
    mon_en = 1'b1;
    drv_en = 1'b1;
    @(posedge clk);
    for (int unsigned i = 0; i < NREQ; i++) add_op(i, 3, 7, 2);
    run_batch(400);

    // Randomized batches with random backpressure.
    rdy_mode = 1;
    for (int unsigned r = 0; r < 10; r++) begin
      logic [NREQ-1:0] mask;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          int unsigned nops;
          nops = $urandom_range(1, 3);
          for (int unsigned k = 0; k < nops; k++) begin
            o = rand_op();
            op_q[i].push_back(o);
          end
        end
      end
      run_batch(4000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/modexp_sched.md
# modexp_sched

Round-robin scheduler that shares one modular-exponentiation engine among `NREQ` requesters in the RSA datapath. It accepts operand sets over per-requester valid/ready handshakes and rejects operand sets the engine cannot compute exactly. It starts the engine with a one-cycle start pulse, waits for engine finish, and returns the result tagged with the requester id over a single valid/ready response channel. The block sits between the encrypt/decrypt clients and the engine instance.

## Interface
- `ARQ`, 16: engine half-width; operand width `W = 2*ARQ`.
- `NREQ`, 4: number of requesters, ≥2; `IDW = $clog2(NREQ)` is derived.
- `TIMEOUT_CYCLES`, 2*ARQ+8: watchdog limit in RUN; used only with `MODEXP_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: request valid, one bit per requester.
- `req_ready` out NREQ: accept strobe, one-hot or zero.
- `req_base` in NREQ*W: packed base operands; requester i occupies `[i*W +: W]`.
- `req_modulo` in NREQ*W: packed moduli.
- `req_exponent` in NREQ*W: packed exponents.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_id` out IDW: requester id of the response.
- `rsp_result` out W: result.
- `rsp_err` out 1: operand rejected or timed out.
- `busy` out 1: high in any state other than IDLE.
- `eng_start` out 1: one-cycle engine start; drives the engine's synchronous load/reset.
- `eng_base`, `eng_modulo`, `eng_exponent` out W each: latched operands; stable from START until the block returns to IDLE.
- `eng_finish` in 1: engine done.
- `eng_result` in W: engine result.

## Operation
- States: IDLE, START, RUN, RESP.

IDLE
- Winner is the first requester with `req_valid` set, searching from `last_grant+1` with wrap-around.
- The winner's `req_ready` is driven combinationally in the same cycle; the operands are latched; `last_grant` is set to the winner id.
- Operand check on the latched values. Reject if `modulo == 0`, or `modulo[W-1:ARQ] != 0`, or `base[W-1:ARQ] != 0`. These keep every engine product within `W` bits.
- On reject: go to RESP with `rsp_err=1` and `rsp_result=0`. The engine is not started.
- Otherwise go to START.

START
- Drive `eng_start=1` for exactly one cycle, then go to RUN.

RUN
- `eng_finish` is ignored in the cycle the block enters RUN; it is sampled from the following cycle.
- On `eng_finish=1`: capture `eng_result`, set `rsp_err=0`, go to RESP.

RESP
- `rsp_valid=1`. `rsp_id`, `rsp_result` and `rsp_err` hold stable until `rsp_ready`.
- On `rsp_ready`: go to IDLE.
- No request is granted before the transition back to IDLE.

Other rules
- A request that keeps `req_valid` high while another requester is served is not dropped.
- The result is passed through unmodified; exponent 0 yields 1.
- Reset values: all outputs 0, state IDLE, `last_grant = NREQ-1` so requester 0 has first priority.
- Reset mid-operation abandons the transaction; no response is issued.

## Timing
- Request accepted in cycle 0.
- Rejected request: `rsp_valid` in cycle 1.
- Accepted request: `eng_start` in cycle 1.
- For an exponent of bit length k, `eng_finish` is first seen in cycle k+3 and `rsp_valid` rises in cycle k+4.
- Worst case is `W+4` cycles.
- `rsp_valid` may rise in the same cycle `rsp_ready` is already high; the handshake then completes that cycle. Earliest next grant is the cycle after.
- Back-to-back throughput: one operation per k+5 cycles at `rsp_ready=1`.

## Configuration
- `MODEXP_TIMEOUT_EN` defined:
  - A RUN-state counter is present; it clears on entry to RUN.
  - If the count reaches `TIMEOUT_CYCLES` without `eng_finish`, go to RESP with `rsp_err=1` and `rsp_result=0`.
  - The next grant re-pulses `eng_start`, which restarts the engine.
- `MODEXP_TIMEOUT_EN` undefined:
  - No counter is present.
  - RUN waits indefinitely for `eng_finish`.

## Test plan
- Requester 0, base 4, modulo 497, exponent 13 (k=4): `req_ready[0]` in cycle 0, one `eng_start` in cycle 1, `rsp_valid` in cycle 8 with result 445, `rsp_id=0`, `rsp_err=0`.
- Requesters 0 and 1 held valid continuously (base 3, modulo 7, exponent 2): grants alternate 0,1,0,1; every result is 2; no grant while `busy`.
- Requester 2 with modulo 0, and separately requester 3 with modulo 0x10000 (ARQ=16): `rsp_err=1` and result 0 in cycle 1; `eng_start` never asserts.
- Backpressure: `rsp_ready` held low 5 cycles during RESP: `rsp_*` stable, no `req_ready`; completes the cycle `rsp_ready` rises.
- Exponent 0, base 7, modulo 11: result 1 with `rsp_valid` in cycle 4. Then assert `reset` in RUN of a new request: all outputs 0 next cycle, no response, requester 0 granted first afterward.
- With `MODEXP_TIMEOUT_EN`, engine stub holding `eng_finish=0`: `rsp_err=1` after `TIMEOUT_CYCLES` cycles in RUN.
